// File: rtl/cpu4_dmem.sv
// ---------------------------------------------------------------------------
// cpu4_dmem -- single-port data memory for a small CPU, with optional MMIO.
//
// One request is in flight at a time. A request is accepted in IDLE. Writes
// are committed on the accept edge. Read data is sampled on the edge that
// enters RESP, and the response is held until it is consumed.
//
// Parameters:
//   ADDR_W   word-address bits; RAM depth is 2**ADDR_W 32-bit words
//   LATENCY  cycles from the accept cycle to the first rsp_valid (1..15)
//
// Ports:
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   req_we              1 = write, 0 = read
//   req_addr            byte address (must be word aligned)
//   req_wdata, req_be   write data and per-byte-lane enables
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           read data (0 for writes and faults)
//   rsp_err             access fault
//   gpio_out            MMIO output register (0 when MMIO is not built)
//
// Build option:
//   CPU4_DMEM_MMIO_EN   when defined, 0xFFFF0000 is gpio_out (R/W) and
//                       0xFFFF0004 is a free-running cycle counter (RO).
//                       Any other address in 0xFFFF0000..0xFFFFFFFF faults.
//                       When the macro is not defined, these addresses are
//                       ordinary out-of-range RAM addresses and fault.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; write commits on the accept edge
// S_WAIT | latency down-counter running (LATENCY > 1 only)
// S_RESP | response valid and held until rsp_ready
// ---------------------------------------------------------------------------
module cpu4_dmem #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] gpio_out
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_GPIO,
        T_CCNT
    } tgt_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cap_rd_q, cap_rd_d;
    logic                cap_err_q, cap_err_d;
    tgt_t                cap_tgt_q, cap_tgt_d;
    logic [ADDR_W-1:0]   cap_idx_q, cap_idx_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [31:0]         mem [DEPTH];

    // Decode of the request currently on the input pins.
    logic                live_err;
    tgt_t                live_tgt;
    logic [ADDR_W-1:0]   live_idx;

    logic                accept;
    logic                enter_resp;
    logic                wr_ram;
    logic                src_rd;
    logic                src_err;
    tgt_t                src_tgt;
    logic [ADDR_W-1:0]   src_idx;
    logic [31:0]         rd_word;

`ifdef CPU4_DMEM_MMIO_EN
    logic [31:0]         gpio_q, gpio_d;
    logic [31:0]         ccnt_q, ccnt_d;
    logic                wr_gpio;
`endif

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    always_comb begin
        live_tgt = T_RAM;
        live_idx = req_addr[ADDR_W+1:2];
        // Misaligned, or any address bit above the RAM word index set.
        live_err = (req_addr[1:0] != 2'b00) ||
                   ((req_addr >> (ADDR_W + 2)) != 32'd0);
`ifdef CPU4_DMEM_MMIO_EN
        if (req_addr[31:16] == 16'hFFFF) begin
            if (req_addr == 32'hFFFF_0000) begin
                live_tgt = T_GPIO;
                live_err = 1'b0;
            end else if (req_addr == 32'hFFFF_0004) begin
                live_tgt = T_CCNT;
                live_err = req_we;          // counter is read-only
            end else begin
                live_err = 1'b1;
            end
        end
`endif
    end

    assign accept = (state_q == S_IDLE) && req_valid;
    assign wr_ram = accept && req_we && !live_err && (live_tgt == T_RAM);

    // With LATENCY=1 the read is sampled on the accept edge itself, so the
    // read source must come straight from the pins rather than the capture.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_rd  = !req_we && !live_err;
            src_err = live_err;
            src_tgt = live_tgt;
            src_idx = live_idx;
        end else begin
            src_rd  = cap_rd_q;
            src_err = cap_err_q;
            src_tgt = cap_tgt_q;
            src_idx = cap_idx_q;
        end
    end

    always_comb begin
        rd_word = 32'd0;
        case (src_tgt)
            T_RAM:   rd_word = mem[src_idx];
`ifdef CPU4_DMEM_MMIO_EN
            T_GPIO:  rd_word = gpio_q;
            T_CCNT:  rd_word = ccnt_q;
`endif
            default: rd_word = 32'd0;
        endcase
    end

    assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // -----------------------------------------------------------------------
    // FSM: next state, counter and transaction capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_rd_d  = cap_rd_q;
        cap_err_d = cap_err_q;
        cap_tgt_d = cap_tgt_q;
        cap_idx_d = cap_idx_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cap_rd_d  = !req_we && !live_err;
                    cap_err_d = live_err;
                    cap_tgt_d = live_tgt;
                    cap_idx_d = live_idx;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response registers: loaded entering RESP, cleared after the handshake.
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_rdata_d = src_rd ? rd_word : 32'd0;
            rsp_err_d   = src_err;
        end else if ((state_q == S_RESP) && rsp_ready) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cap_rd_q    <= 1'b0;
            cap_err_q   <= 1'b0;
            cap_tgt_q   <= T_RAM;
            cap_idx_q   <= '0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_rd_q    <= cap_rd_d;
            cap_err_q   <= cap_err_d;
            cap_tgt_q   <= cap_tgt_d;
            cap_idx_q   <= cap_idx_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAM: no reset on contents; byte-lane writes on the accept edge.
    // Writes are suppressed while reset is held so a request presented
    // during reset cannot corrupt memory.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_ram && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[live_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // MMIO registers
    // -----------------------------------------------------------------------
`ifdef CPU4_DMEM_MMIO_EN
    assign wr_gpio = accept && req_we && !live_err && (live_tgt == T_GPIO);

    always_comb begin
        gpio_d = gpio_q;
        if (wr_gpio) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    gpio_d[8*i +: 8] = req_wdata[8*i +: 8];
                end
            end
        end
        ccnt_d = ccnt_q + 32'd1;          // wraps naturally at 2**32
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= 32'd0;
            ccnt_q <= 32'd0;
        end else begin
            gpio_q <= gpio_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign gpio_out = gpio_q;
`else
    assign gpio_out = 32'd0;
`endif

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/cpu4_dmem.md
CPU4_DMEM -- requirements
Module: cpu4_dmem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address bits; storage depth is 2^ADDR_W words.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request accept to first rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte enables, bit i selects byte lane [8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed this cycle when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  access fault for this response.
REQ-015 SHALL have port gpio_out  output  32  MMIO output register.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-017 SHALL, on accept with LATENCY=1, go IDLE->RESP; else IDLE->WAIT with down-counter loaded to LATENCY-2, WAIT->RESP when counter = 0.
REQ-018 SHALL assert rsp_valid only in RESP, exactly LATENCY cycles after the accept cycle; hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready, then return to IDLE.
REQ-019 SHALL capture req_we, req_addr, req_wdata, req_be at accept; later input changes have no effect on the transaction.
REQ-020 SHALL flag misaligned (req_addr[1:0] != 0) as error: no write, rsp_err=1, rsp_rdata=0.
REQ-021 SHALL flag RAM-region address with any of req_addr[31:ADDR_W+2] nonzero (and not MMIO per REQ-030) as error: no write.
REQ-022 SHALL use word index req_addr[ADDR_W+1:2] for RAM.
REQ-023 SHALL commit writes on the accept edge, only enabled byte lanes; req_be=0 is a legal no-op write with rsp_err=0.
REQ-024 SHALL sample read data at the edge entering RESP, full 32-bit word regardless of req_be.
REQ-025 SHALL, with rsp_ready held high, accept next request in the cycle after the RESP handshake (one idle cycle minimum between responses).
REQ-026 SHALL treat req_valid low in IDLE as no-op; no state change.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, gpio_out=0, cycle counter 0; req_ready=1 after release.
REQ-028 SHALL abandon any in-flight transaction on reset assertion mid-operation; a write already committed at accept stays committed; no response is issued.
REQ-029 SHALL NOT reset RAM contents.

Configuration
REQ-030 SHALL, with macro CPU4_DMEM_MMIO_EN defined, decode 0xFFFF0000 as gpio_out (read/write, byte enables honoured) and 0xFFFF0004 as 32-bit free-running cycle counter (read-only, wraps 0xFFFFFFFF->0; write gives rsp_err=1).
REQ-031 SHALL, with CPU4_DMEM_MMIO_EN defined, flag any other address in 0xFFFF0000..0xFFFFFFFF as error.
REQ-032 SHALL, without CPU4_DMEM_MMIO_EN, tie gpio_out to 0, omit the cycle counter, and treat 0xFFFF00xx like any other out-of-range RAM address (error).

Verification
REQ-033 SHALL cover: LATENCY=3, write 0xDEADBEEF be=4'hF to 0x10, read 0x10 -> rsp_valid exactly 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: write 0x11223344 be=4'b0101 over 0xFFFFFFFF at 0x20, read -> 0xFF22FF44.
REQ-035 SHALL cover: read 0x0000_0402 (misaligned) and 0x0000_0400 with ADDR_W=8 -> both err=1, rdata 0, RAM unchanged.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; accept resumes cycle after handshake.
REQ-037 SHALL cover: MMIO_EN on, write 0x000000A5 to 0xFFFF0000 -> gpio_out=0x000000A5; write 0xFFFF0004 -> err=1; two reads of 0xFFFF0004 accepted N cycles apart differ by N. MMIO_EN off -> same write err=1, gpio_out=0.
REQ-038 SHALL cover: reset pulsed low while in WAIT -> rsp_valid never asserted, outputs zero, next request served normally.
